// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Brief   : Instruction fetch stage with IF/ID register, redirect and fault FSM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int unsigned IMEM_BYTES = 400
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [15:0] fetch_count
);

    localparam logic [31:0] c_LAST_PC    = IMEM_BYTES - 4;
    localparam logic [1:0]  c_CODE_NONE  = 2'b00;
    localparam logic [1:0]  c_CODE_ALIGN = 2'b01;
    localparam logic [1:0]  c_CODE_RANGE = 2'b10;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [1:0]  r_fault_code;
    logic [15:0] r_fetch_count;

    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_pc_bad;
    logic [1:0]  w_bad_code;
    logic        w_advance;
    logic        w_accept;

    // Misalignment wins over out-of-range when both apply.
    assign w_misaligned   = (r_pc[1:0] != 2'b00);
    assign w_out_of_range = (r_pc > c_LAST_PC);
    assign w_pc_bad       = w_misaligned || w_out_of_range;
    assign w_bad_code     = w_misaligned   ? c_CODE_ALIGN :
                            w_out_of_range ? c_CODE_RANGE : c_CODE_NONE;
    assign w_advance      = !r_if_valid || id_ready;
    assign w_accept       = r_if_valid && id_ready && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_instr    <= 32'd0;
            r_if_pc       <= 32'd0;
            r_fault_code  <= c_CODE_NONE;
            r_fetch_count <= 16'd0;
        end else begin
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end

            // A redirect flushes the IF/ID entry regardless of decode readiness.
            if (redirect_valid) begin
                r_state      <= S_RUN;
                r_pc         <= redirect_pc;
                r_if_valid   <= 1'b0;
                r_fault_code <= c_CODE_NONE;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (w_pc_bad) begin
                            r_state      <= S_FAULT;
                            r_fault_code <= w_bad_code;
                            if (id_ready) begin
                                r_if_valid <= 1'b0;
                            end
                        end else if (w_advance) begin
                            r_if_instr <= instr_in;
                            r_if_pc    <= r_pc;
                            r_if_valid <= 1'b1;
                            r_pc       <= r_pc + 32'd4;
                        end
                    end
                    S_FAULT: begin
                        if (id_ready) begin
                            r_if_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_RUN;
                    end
                endcase
            end
        end
    end

    assign pc_out      = r_pc;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc4      = r_if_pc + 32'd4;
    assign fault       = (r_state == S_FAULT);
    assign fault_code  = r_fault_code;
    assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Directed vector bench for fetch_stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] c_KEY = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        fault;
    logic [1:0]  fault_code;
    logic [15:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instruction memory: each word is its own address scrambled by a key.
    assign instr_in = pc_out ^ c_KEY;

    fetch_stage #(
        .RESET_PC   (32'd0),
        .IMEM_BYTES (400)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_out         (pc_out),
        .instr_in       (instr_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .fault          (fault),
        .fault_code     (fault_code),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        v;
        logic [31:0] ipc;
        logic [31:0] pco;
        logic        f;
        logic [1:0]  fc;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                                input logic v, input logic [31:0] ipc, input logic [31:0] pco,
                                input logic f, input logic [1:0] fc, input logic [15:0] cnt);
        vec_t t;
        t.rv = rv; t.rpc = rpc; t.rdy = rdy; t.v = v; t.ipc = ipc;
        t.pco = pco; t.f = f; t.fc = fc; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".pc_out"},      pc_out, 32'd0);
        chk({tag, ".if_valid"},    {31'd0, if_valid}, 32'd0);
        chk({tag, ".if_instr"},    if_instr, 32'd0);
        chk({tag, ".if_pc"},       if_pc, 32'd0);
        chk({tag, ".if_pc4"},      if_pc4, 32'd4);
        chk({tag, ".fault"},       {31'd0, fault}, 32'd0);
        chk({tag, ".fault_code"},  {30'd0, fault_code}, 32'd0);
        chk({tag, ".fetch_count"}, {16'd0, fetch_count}, 32'd0);
    endtask

    initial begin
        int m_cnt;
        int phase;
        logic m_valid;
        logic rv;

        // Sequential fetch, stall, redirect, misaligned and out-of-range faults.
        vt.push_back(mk(0, 0,     1, 1, 32'd0,   32'd4,   0, 2'b00, 16'd0));
        vt.push_back(mk(0, 0,     1, 1, 32'd4,   32'd8,   0, 2'b00, 16'd1));
        vt.push_back(mk(0, 0,     1, 1, 32'd8,   32'd12,  0, 2'b00, 16'd2));
        vt.push_back(mk(0, 0,     0, 1, 32'd8,   32'd12,  0, 2'b00, 16'd2));
        vt.push_back(mk(0, 0,     0, 1, 32'd8,   32'd12,  0, 2'b00, 16'd2));
        vt.push_back(mk(0, 0,     0, 1, 32'd8,   32'd12,  0, 2'b00, 16'd2));
        vt.push_back(mk(0, 0,     1, 1, 32'd12,  32'd16,  0, 2'b00, 16'd3));
        vt.push_back(mk(0, 0,     1, 1, 32'd16,  32'd20,  0, 2'b00, 16'd4));
        vt.push_back(mk(1, 'h40,  0, 0, 32'd16,  32'h40,  0, 2'b00, 16'd4));
        vt.push_back(mk(0, 0,     0, 1, 32'h40,  32'h44,  0, 2'b00, 16'd4));
        vt.push_back(mk(0, 0,     1, 1, 32'h44,  32'h48,  0, 2'b00, 16'd5));
        vt.push_back(mk(1, 'h22,  1, 0, 32'h44,  32'h22,  0, 2'b00, 16'd5));
        vt.push_back(mk(0, 0,     1, 0, 32'h44,  32'h22,  1, 2'b01, 16'd5));
        vt.push_back(mk(0, 0,     0, 0, 32'h44,  32'h22,  1, 2'b01, 16'd5));
        vt.push_back(mk(1, 'h20,  0, 0, 32'h44,  32'h20,  0, 2'b00, 16'd5));
        vt.push_back(mk(0, 0,     1, 1, 32'h20,  32'h24,  0, 2'b00, 16'd5));
        vt.push_back(mk(0, 0,     1, 1, 32'h24,  32'h28,  0, 2'b00, 16'd6));
        vt.push_back(mk(1, 392,   1, 0, 32'h24,  32'd392, 0, 2'b00, 16'd6));
        vt.push_back(mk(0, 0,     1, 1, 32'd392, 32'd396, 0, 2'b00, 16'd6));
        vt.push_back(mk(0, 0,     1, 1, 32'd396, 32'd400, 0, 2'b00, 16'd7));
        vt.push_back(mk(0, 0,     0, 1, 32'd396, 32'd400, 1, 2'b10, 16'd7));
        vt.push_back(mk(0, 0,     0, 1, 32'd396, 32'd400, 1, 2'b10, 16'd7));
        vt.push_back(mk(0, 0,     1, 0, 32'd396, 32'd400, 1, 2'b10, 16'd8));
        vt.push_back(mk(0, 0,     1, 0, 32'd396, 32'd400, 1, 2'b10, 16'd8));
        vt.push_back(mk(1, 0,     1, 0, 32'd396, 32'd0,   0, 2'b00, 16'd8));
        vt.push_back(mk(0, 0,     1, 1, 32'd0,   32'd4,   0, 2'b00, 16'd8));
        vt.push_back(mk(1, 392,   0, 0, 32'd0,   32'd392, 0, 2'b00, 16'd8));
        vt.push_back(mk(0, 0,     1, 1, 32'd392, 32'd396, 0, 2'b00, 16'd8));
        vt.push_back(mk(0, 0,     1, 1, 32'd396, 32'd400, 0, 2'b00, 16'd9));
        vt.push_back(mk(0, 0,     1, 0, 32'd396, 32'd400, 1, 2'b10, 16'd10));
        vt.push_back(mk(1, 0,     1, 0, 32'd396, 32'd0,   0, 2'b00, 16'd10));

        #2;
        chk_reset_values("reset");
        #6;
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vt[i].rv, vt[i].rpc, vt[i].rdy);
            chk({tag, ".if_valid"},    {31'd0, if_valid}, {31'd0, vt[i].v});
            chk({tag, ".if_pc"},       if_pc, vt[i].ipc);
            chk({tag, ".if_pc4"},      if_pc4, vt[i].ipc + 32'd4);
            chk({tag, ".pc_out"},      pc_out, vt[i].pco);
            chk({tag, ".fault"},       {31'd0, fault}, {31'd0, vt[i].f});
            chk({tag, ".fault_code"},  {30'd0, fault_code}, {30'd0, vt[i].fc});
            chk({tag, ".fetch_count"}, {16'd0, fetch_count}, {16'd0, vt[i].cnt});
            if (vt[i].v) begin
                chk({tag, ".if_instr"}, if_instr, vt[i].ipc ^ c_KEY);
            end
        end

        // Asynchronous reset between edges while faulted and holding an entry.
        step(0, 0, 1);
        step(1, 32'd6, 0);
        step(0, 0, 0);
        chk("pre_rst.fault", {31'd0, fault}, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_rst");
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_cap.if_valid", {31'd0, if_valid}, 32'd1);
        chk("first_cap.if_pc",    if_pc, 32'd0);
        chk("first_cap.if_instr", if_instr, c_KEY);
        chk("first_cap.pc_out",   pc_out, 32'd4);

        // Counter wrap: periodic redirects keep the PC inside the memory.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_cnt   = 0;
        m_valid = 1'b0;
        phase   = 0;
        while (m_cnt < 65536) begin
            rv = (phase == 49);
            step(rv, 32'd0, 1'b1);
            if (m_valid && !rv) begin
                m_cnt++;
            end
            m_valid = !rv;
            phase   = (phase == 49) ? 0 : phase + 1;
            if (m_valid && !rv && m_cnt == 65535) begin
                chk("wrap.ffff", {16'd0, fetch_count}, 32'h0000_FFFF);
            end
        end
        chk("wrap.zero", {16'd0, fetch_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'd0, which is the first fetch address after reset.
REQ-002 The block SHALL have parameter IMEM_BYTES, default 400, which is the instruction memory size in bytes.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk: input, 1 bit, sole clock, rising edge.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port pc_out: output, 32 bits, current fetch byte address, driven to the instruction memory read address.
REQ-007 Port instr_in: input, 32 bits, combinational instruction word returned by the instruction memory for pc_out.
REQ-008 Port redirect_valid: input, 1 bit, branch/jump redirect request.
REQ-009 Port redirect_pc: input, 32 bits, redirect target byte address.
REQ-010 Port id_ready: input, 1 bit, decode stage can accept the IF/ID entry this cycle.
REQ-011 Port if_valid: output, 1 bit, the IF/ID entry is valid.
REQ-012 Port if_instr: output, 32 bits, registered instruction word.
REQ-013 Port if_pc: output, 32 bits, address of if_instr.
REQ-014 Port if_pc4: output, 32 bits, if_pc + 4, modulo 2^32.
REQ-015 Port fault: output, 1 bit, high while the state machine is in FAULT.
REQ-016 Port fault_code: output, 2 bits; 00 = none, 01 = misaligned, 10 = out of range.
REQ-017 Port fetch_count: output, 16 bits, number of accepted handshakes, wrapping.

Function
REQ-018 The block SHALL drive pc_out directly from the PC register, with no combinational path from any input.
REQ-019 The block SHALL define pc_bad as pc[1:0] != 0 (code 01), else pc > IMEM_BYTES-4 (code 10); misaligned takes precedence.
REQ-020 The block SHALL define advance = (!if_valid || id_ready) in state RUN.
REQ-021 The state machine SHALL have two states, RUN and FAULT; reset state is RUN.
REQ-022 In RUN with advance, no redirect, and !pc_bad, the block SHALL on the next edge load if_instr <= instr_in, if_pc <= pc, if_valid <= 1, and pc <= pc + 4.
REQ-023 In RUN with !advance and no redirect, the block SHALL hold the PC and all IF/ID outputs unchanged (stall).
REQ-024 In RUN with pc_bad and no redirect, the block SHALL go to FAULT, latch fault_code, hold the PC, and capture nothing.
REQ-025 The block SHALL clear if_valid on id_ready even in that pc_bad cycle.
REQ-026 redirect_valid SHALL have the highest priority in either state: pc <= redirect_pc, if_valid <= 0 (flush, even if id_ready = 0), state <= RUN, fault_code <= 00.
REQ-027 A redirect SHALL produce one bubble cycle; the target is captured on the following edge.
REQ-028 A redirect to a bad target SHALL be accepted; the fault is detected in the next cycle per REQ-024.
REQ-029 In FAULT, the block SHALL hold the PC, capture nothing, and clear if_valid once it is consumed (id_ready = 1).
REQ-030 FAULT SHALL be exited only by redirect or reset.
REQ-031 fetch_count SHALL increment when if_valid && id_ready && !redirect_valid, and wrap 16'hFFFF -> 0.
REQ-032 A flushed entry (redirect in the same cycle) SHALL NOT be counted.
REQ-033 The PC increment SHALL be 32-bit modulo; wrap beyond IMEM_BYTES is caught as out of range, never fetched.

Reset
REQ-034 On rst_n low, the block SHALL set immediately, regardless of clk: pc = RESET_PC, if_valid = 0, if_instr = 0, if_pc = 0, if_pc4 = 4, fault = 0, fault_code = 00, fetch_count = 0, state RUN.
REQ-035 Reset asserted mid-stall or mid-fault SHALL discard the pending entry.
REQ-036 The first capture SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-037 Reset, id_ready = 1, memory words W0..W3 -> if_pc sequence 0, 4, 8, 12 on consecutive cycles; fetch_count = 4 after 4 accepts.
REQ-038 if_valid = 1, if_pc = 8, id_ready = 0 for 3 cycles -> if_instr, if_pc and pc_out = 12 stable; fetch_count unchanged.
REQ-039 redirect_valid with redirect_pc = 0x40 while id_ready = 0 -> next cycle if_valid = 0, pc_out = 0x40; following cycle if_pc = 0x40; the flushed entry is not counted.
REQ-040 Sequential fetch to pc = 396 -> captured; pc = 400 -> fault = 1, fault_code = 10, pc_out holds 400, if_valid drops after consume; redirect to 0 -> RUN, fault = 0.
REQ-041 Redirect to 0x22 -> fault_code = 01 the next cycle; redirect to 0x20 in FAULT -> recovers, if_pc = 0x20 two cycles later.
REQ-042 rst_n pulsed low between clock edges while in FAULT -> outputs reach reset values immediately; 65536 accepts -> fetch_count wraps to 0.
